serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder/subtractor with valid/ready handshakes on both sides. It is the multi-bit, sequential successor to the single-bit `full_adder`. One instance of `full_adder` is reused over `WIDTH` clock cycles, LSB first, with the carry held in a register. It serves as the low-area arithmetic unit for datapaths where throughput of one result per `WIDTH+2` cycles is sufficient.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `sys_clk` input, 1 bit: system clock; all state changes on the rising edge.
- `sys_rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: operands and mode are valid.
- `in_ready` output, 1 bit: block can accept an operation. Equals 1 exactly when the state is IDLE.
- `in_1` input, `WIDTH` bits: operand A.
- `in_2` input, `WIDTH` bits: operand B.
- `cin` input, 1 bit: carry-in in add mode; borrow-in in subtract mode.
- `op_sub` input, 1 bit: 0 selects A+B+cin; 1 selects A−B−cin.
- `out_valid` output, 1 bit: result is valid.
- `out_ready` input, 1 bit: consumer takes the result.
- `sum` output, `WIDTH` bits: result.
- `count` output, 1 bit: carry-out. In subtract mode, 1 means no borrow (A ≥ B+cin, unsigned).
- `overflow` output, 1 bit: signed two's-complement overflow.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`=1, capture the operands:
    - `a_sh` ← `in_1`.
    - `b_sh` ← `op_sub` ? ~`in_2` : `in_2`.
    - `carry` ← `cin` ^ `op_sub`.
    - `bit_cnt` ← 0.
  - Then go to RUN.
- **RUN**
  - Each cycle, the `full_adder` takes `a_sh[0]`, `b_sh[0]` and `carry`.
  - Its sum bit shifts into `sum_sh[WIDTH-1]`, and `sum_sh` shifts right.
  - `a_sh` and `b_sh` shift right, and `carry` ← the adder's carry-out.
  - When `bit_cnt`=`WIDTH-2`, latch `carry` into `c_msb_in`; this is the carry into the MSB.
  - When `bit_cnt`=`WIDTH-1`, go to DONE; otherwise increment `bit_cnt`.
- **DONE**
  - `out_valid`=1.
  - `sum`=`sum_sh`, `count`=`carry`, `overflow`=`c_msb_in` ^ `carry`.
  - All three outputs are registered and held stable until `out_ready`=1, then return to IDLE.
- Inputs are sampled only on the accept edge. Changes to `in_1`, `in_2`, `cin` or `op_sub` during RUN or DONE have no effect.
- `in_valid` is ignored outside IDLE. A new operation is not accepted in the same cycle as the output handshake.
- All results are modulo 2^`WIDTH`. No saturation.
- Reset (asynchronous, at any time including mid-RUN):
  - State → IDLE.
  - All shift registers, `carry`, `c_msb_in` and `bit_cnt` → 0.
  - `sum`=0, `count`=0, `overflow`=0, `out_valid`=0, `in_ready`=1.
  - An aborted operation never produces `out_valid`.

## Timing
- Accept edge is T0, where `in_valid` and `in_ready` are both 1.
- RUN occupies the edges T1…T`WIDTH`.
- `out_valid` rises after edge T`WIDTH`, so latency is `WIDTH` cycles from the accept edge.
- With `out_ready` tied high:
  - DONE lasts 1 cycle.
  - `in_ready` returns after edge T`WIDTH+1`.
  - Minimum issue interval is `WIDTH+2` cycles.
- `out_ready` low holds DONE indefinitely, with outputs unchanged and `in_ready`=0.
- `in_ready` is a pure decode of registered state, with no combinational path from `out_ready` or `in_valid`.

## Structure
- Shared package `serial_adder_pkg` contains:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - A `clog2` function that sizes `bit_cnt` as clog2(`WIDTH`).
- Sub-module: one `full_adder` instance, which is the existing single-bit cell. It is the only combinational arithmetic in the block.
- All other logic is the FSM, counter and shift registers in `serial_adder`.

## Test plan
All scenarios use `WIDTH`=8.
1. Add 100+27, `cin`=0: `sum`=127, `count`=0, `overflow`=0. `out_valid` asserts exactly 8 cycles after the accept edge.
2. Add 8'hFF+8'h01, `cin`=0: `sum`=8'h00, `count`=1, `overflow`=0. Then add 8'h7F+8'h00, `cin`=1: `sum`=8'h80, `count`=0, `overflow`=1.
3. Subtract 5−7, `cin`=0: `sum`=8'hFE, `count`=0, `overflow`=0. Then subtract 8'h80−8'h01: `sum`=8'h7F, `count`=1, `overflow`=1.
4. Backpressure: hold `out_ready`=0 for 5 cycles in DONE, toggling `in_valid` and the operands meanwhile.
   - Outputs stay stable and `in_ready` stays 0.
   - After `out_ready`=1, the next operation is accepted one cycle later and computes from its own sampled operands.
5. Assert reset during RUN at `bit_cnt`=3.
   - Outputs are immediately 0 and `in_ready`=1.
   - No `out_valid` appears.
   - The following 8'h12+8'h34 gives `sum`=8'h46.
6. Back-to-back ops with `out_ready`=1 and `in_valid`=1 held: the issue interval is exactly 10 cycles and each result is correct.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding and
// the counter-sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one full_adder reused over WIDTH
// cycles with valid/ready handshakes on input and output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             count,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | one bit per cycle through the full adder
  // DONE  | result registered, waiting for out_ready

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic             c_msb_in;
  logic [CW-1:0]    bit_cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      c_msb_in  <= 1'b0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      count     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // subtraction is A + ~B + 1, with borrow-in folded into the carry
            a_sh    <= in_1;
            b_sh    <= op_sub ? ~in_2 : in_2;
            carry   <= cin ^ op_sub;
            bit_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          if (bit_cnt == PENULT) c_msb_in <= fa_co;
          if (bit_cnt == LAST) begin
            // final bit: carry register holds the carry into the MSB
            state     <= DONE;
            out_valid <= 1'b1;
            sum       <= {fa_s, sum_sh[WIDTH-1:1]};
            count     <= fa_co;
            overflow  <= carry ^ fa_co;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
